// File: rtl/fir_controller.sv
// fir_controller: sequencer for the shared 4-tap FIR datapath.
// Issues the 13-step shift/multiply/accumulate sequence per sample and
// arbitrates the datapath between that sequence and coefficient loads.
module fir_controller (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dr,
    input  logic       lc,
    input  logic [1:0] coefficient_num,
    input  logic       overflow,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       cnt_up,
    output logic       clear,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE, EIDLE, SH3, SH2, SH1, STORE, MUL0, CPY0,
        MUL1, SUB1, MUL2, ADD2, MUL3, SUB3, DONE, LOADC
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LOAD1 = 3'b010;
    localparam logic [2:0] OP_LOAD2 = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic [1:0] pidx_q, pidx_d;
    logic [1:0] cidx_q, cidx_d;
    logic       modwait_q, modwait_d;
    logic       err_q, err_d;

    // State, pending-request and handshake flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            pidx_q    <= '0;
            cidx_q    <= '0;
            modwait_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pidx_q    <= pidx_d;
            cidx_q    <= cidx_d;
            modwait_q <= modwait_d;
            err_q     <= err_d;
        end
    end

    // Next-state, pending capture and registered flag inputs
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pidx_d    = pidx_q;
        cidx_d    = cidx_q;
        unique case (state_q)
            IDLE, EIDLE: begin
                if (lc) begin
                    state_d = LOADC;
                    cidx_d  = coefficient_num;
                end else if (pending_q) begin
                    state_d = LOADC;
                    cidx_d  = pidx_q;
                end else if (dr) begin
                    state_d = SH3;
                end
            end
            SH3:   state_d = SH2;
            SH2:   state_d = SH1;
            SH1:   state_d = STORE;
            STORE: state_d = MUL0;
            MUL0:  state_d = CPY0;
            CPY0:  state_d = MUL1;
            MUL1:  state_d = SUB1;
            SUB1:  state_d = overflow ? EIDLE : MUL2;
            MUL2:  state_d = ADD2;
            ADD2:  state_d = overflow ? EIDLE : MUL3;
            MUL3:  state_d = SUB3;
            SUB3:  state_d = overflow ? EIDLE : DONE;
            // A request queued during the sequence is serviced straight
            // out of DONE so the loader sees no idle gap; an lc in DONE
            // itself is the newest index and replaces the queued one.
            DONE: begin
                if (pending_q) begin
                    state_d = LOADC;
                    cidx_d  = lc ? coefficient_num : pidx_q;
                end else begin
                    state_d = IDLE;
                end
            end
            LOADC: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (lc && state_q != IDLE && state_q != EIDLE) begin
            pending_d = 1'b1;
            pidx_d    = coefficient_num;
        end
        if (state_d == LOADC) begin
            pending_d = 1'b0;
        end

        modwait_d = (state_d != IDLE && state_d != EIDLE) || pending_d;
        err_d     = (state_d == EIDLE);
    end

    // Moore datapath control decoded from the current state
    always_comb begin
        op     = OP_NOP;
        src1   = '0;
        src2   = '0;
        dest   = '0;
        cnt_up = 1'b0;
        clear  = 1'b0;
        unique case (state_q)
            SH3:   begin op = OP_COPY;  src1 = 4'd3;  dest = 4'd4; end
            SH2:   begin op = OP_COPY;  src1 = 4'd2;  dest = 4'd3; end
            SH1:   begin op = OP_COPY;  src1 = 4'd1;  dest = 4'd2; end
            STORE: begin op = OP_LOAD1; dest = 4'd1; end
            MUL0:  begin op = OP_MUL;   src1 = 4'd1;  src2 = 4'd6;  dest = 4'd10; end
            CPY0:  begin op = OP_COPY;  src1 = 4'd10; dest = 4'd0; end
            MUL1:  begin op = OP_MUL;   src1 = 4'd2;  src2 = 4'd7;  dest = 4'd10; end
            SUB1:  begin op = OP_SUB;   src1 = 4'd0;  src2 = 4'd10; dest = 4'd0; end
            MUL2:  begin op = OP_MUL;   src1 = 4'd3;  src2 = 4'd8;  dest = 4'd10; end
            ADD2:  begin op = OP_ADD;   src1 = 4'd0;  src2 = 4'd10; dest = 4'd0; end
            MUL3:  begin op = OP_MUL;   src1 = 4'd4;  src2 = 4'd9;  dest = 4'd10; end
            SUB3:  begin op = OP_SUB;   src1 = 4'd0;  src2 = 4'd10; dest = 4'd0; end
            DONE:  begin cnt_up = 1'b1; end
            LOADC: begin
                op    = OP_LOAD2;
                dest  = 4'd6 + {2'b00, cidx_q};
                clear = (cidx_q == 2'd0);
            end
            default: ;
        endcase
    end

    assign modwait = modwait_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fir_controller.sv
// tb_fir_controller: scripted and randomized stimulus checked each cycle
// against a step-counter reference model of the FIR sequencer.
module tb_fir_controller;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dr, lc, overflow;
    logic [1:0] coefficient_num;
    logic       modwait, cnt_up, clear, err;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    fir_controller dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .dr              (dr),
        .lc              (lc),
        .coefficient_num (coefficient_num),
        .overflow        (overflow),
        .modwait         (modwait),
        .op              (op),
        .src1            (src1),
        .src2            (src2),
        .dest            (dest),
        .cnt_up          (cnt_up),
        .clear           (clear),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Op table for sequence steps 1..13 (SH3 .. DONE)
    int unsigned t_op [1:13] = '{1, 1, 1, 2, 6, 1, 6, 5, 6, 4, 6, 5, 0};
    int unsigned t_s1 [1:13] = '{3, 2, 1, 0, 1, 10, 2, 0, 3, 0, 4, 0, 0};
    int unsigned t_s2 [1:13] = '{0, 0, 0, 0, 6, 0, 7, 10, 8, 10, 9, 10, 0};
    int unsigned t_d  [1:13] = '{4, 3, 2, 1, 10, 0, 10, 0, 10, 0, 10, 0, 0};

    // Model: step 0 = idle (either kind), 1..13 = sequence step, 14 = coefficient load
    int unsigned m_step;
    bit          m_pend, m_err, m_mw;
    int unsigned m_pidx, m_cidx;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step = 0; m_pend = 0; m_err = 0; m_mw = 0; m_pidx = 0; m_cidx = 0;
    endtask

    task automatic model_advance(input bit i_dr, input bit i_lc, input int unsigned i_idx, input bit i_ovf);
        if (m_step == 0) begin
            if (i_lc) begin
                m_step = 14; m_cidx = i_idx; m_pend = 0; m_err = 0;
            end else if (m_pend) begin
                m_step = 14; m_cidx = m_pidx; m_pend = 0; m_err = 0;
            end else if (i_dr) begin
                m_step = 1; m_err = 0;
            end
        end else if (m_step == 13) begin
            if (m_pend) begin
                m_step = 14; m_cidx = i_lc ? i_idx : m_pidx; m_pend = 0;
            end else begin
                m_step = 0;
                if (i_lc) begin m_pend = 1; m_pidx = i_idx; end
            end
        end else begin
            if (i_lc) begin m_pend = 1; m_pidx = i_idx; end
            if (m_step == 14) begin
                m_step = 0;
            end else if ((m_step == 8 || m_step == 10 || m_step == 12) && i_ovf) begin
                m_step = 0; m_err = 1;
            end else begin
                m_step++;
            end
        end
        m_mw = (m_step != 0) || m_pend;
    endtask

    // Check this cycle's outputs, drive the next inputs, advance the model.
    task automatic cyc(input bit i_dr, input bit i_lc, input int unsigned i_idx,
                       input bit i_ovf, input bit i_nrst);
        int unsigned e_op, e_s1, e_s2, e_d;
        bit e_cnt, e_clr;
        e_op = 0; e_s1 = 0; e_s2 = 0; e_d = 0; e_cnt = 0; e_clr = 0;
        if (m_step >= 1 && m_step <= 13) begin
            e_op = t_op[m_step]; e_s1 = t_s1[m_step];
            e_s2 = t_s2[m_step]; e_d = t_d[m_step];
            e_cnt = (m_step == 13);
        end else if (m_step == 14) begin
            e_op = 3; e_d = 6 + m_cidx; e_clr = (m_cidx == 0);
        end
        check_eq("op", 32'(op), e_op);
        check_eq("src1", 32'(src1), e_s1);
        check_eq("src2", 32'(src2), e_s2);
        check_eq("dest", 32'(dest), e_d);
        check_eq("cnt_up", 32'(cnt_up), 32'(e_cnt));
        check_eq("clear", 32'(clear), 32'(e_clr));
        check_eq("modwait", 32'(modwait), 32'(m_mw));
        check_eq("err", 32'(err), 32'(m_err));

        dr = i_dr; lc = i_lc; coefficient_num = 2'(i_idx); overflow = i_ovf; n_rst = i_nrst;
        if (!i_nrst) model_reset();
        else model_advance(i_dr, i_lc, i_idx, i_ovf);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        n_rst = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0; coefficient_num = '0;
        model_reset();
        @(negedge clk);
        cyc(0, 0, 0, 0, 1);
        idle(2);

        // Full sample sequence
        cyc(1, 0, 0, 0, 1);
        idle(15);

        // Coefficient loads 0..3
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, i, 0, 1);
            idle(2);
        end

        // lc and dr together: load wins, dr dropped
        cyc(1, 1, 2, 0, 1);
        idle(4);

        // lc at T+5 of a sequence
        cyc(1, 0, 0, 0, 1);
        idle(4);
        cyc(0, 1, 2, 0, 1);
        idle(12);

        // Overflow during ADD2, then recovery by dr
        cyc(1, 0, 0, 0, 1);
        idle(9);
        cyc(0, 0, 0, 1, 1);
        idle(2);
        cyc(1, 0, 0, 0, 1);
        idle(15);

        // Reset in MUL2 with a pending load
        cyc(1, 0, 0, 0, 1);
        idle(2);
        cyc(0, 1, 3, 0, 1);
        idle(5);
        cyc(0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 1);
        idle(15);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(3) == 0), ($urandom_range(9) == 0), $urandom_range(3),
                ($urandom_range(5) == 0), ($urandom_range(199) != 0));
        end
        idle(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
